banked_sram: RTL and testbench

Multi-port, bank-interleaved on-chip memory for the FFT pipeline's twiddle/ping-pong buffers. It generalises the existing `sram` macro wrapper in three ways: any number of ports share one clock, the storage is split into independently accessible banks, and per-bank round-robin arbitration provides a req/gnt handshake. Read data returns with a valid flag after a configurable latency. It sits between the butterfly stages and the buffer storage, so several stages can access memory in the same cycle whenever their addresses fall in different banks.

---
 rtl/banked_sram_pkg.sv | 31 +++
 rtl/banked_sram_rr_arbiter.sv | 50 +++++
 rtl/sram.sv | 40 ++++
 rtl/banked_sram.sv | 160 ++++++++++++++++
 tb/tb_banked_sram.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/banked_sram_pkg.sv
// banked_sram_pkg: shared helpers for the banked SRAM.
//   bank_sel_bits   - number of address bits that select a bank
//   idx_bits        - width of an index over n items (never below 1)
//   bank_addr_split - splits a word address into {bank, row}
package banked_sram_pkg;

  localparam int MaxAddrWidth = 32;

  typedef struct packed {
    logic [MaxAddrWidth-1:0] bank;
    logic [MaxAddrWidth-1:0] row;
  } addr_split_t;

  function automatic int bank_sel_bits(input int num_banks);
    return $clog2(num_banks);
  endfunction

  function automatic int idx_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Low address bits pick the bank so consecutive words land in consecutive banks.
  function automatic addr_split_t bank_addr_split(input logic [MaxAddrWidth-1:0] addr,
                                                  input int bank_bits);
    addr_split_t s;
    s.bank = addr & ~({MaxAddrWidth{1'b1}} << bank_bits);
    s.row  = addr >> bank_bits;
    return s;
  endfunction

endpackage

// File: rtl/banked_sram_rr_arbiter.sv
// rr_arbiter: round-robin arbiter with a registered priority pointer.
//   clk, rst_n - clock, async active-low reset
//   req        - request vector
//   gnt        - one-hot grant
//   idx        - index of the granted requester
//   valid      - some requester was granted
// The pointer moves one past the winner and holds while nobody requests.
module rr_arbiter
  import banked_sram_pkg::*;
#(
  parameter int  NumReq   = 2,
  localparam int IdxWidth = idx_bits(NumReq)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NumReq-1:0]   req,
  output logic [NumReq-1:0]   gnt,
  output logic [IdxWidth-1:0] idx,
  output logic                valid
);

  logic [IdxWidth-1:0] ptr;

  // Scan requesters starting at the pointer, wrapping once.
  always_comb begin
    int cand;
    cand  = 0;
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    for (int i = 0; i < NumReq; i++) begin
      cand = int'(ptr) + i;
      if (cand >= NumReq) cand = cand - NumReq;
      if (!valid && req[cand]) begin
        valid     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = IdxWidth'(cand);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (valid) begin
      ptr <= (int'(idx) == NumReq - 1) ? '0 : idx + 1'b1;
    end
  end

endmodule

// File: rtl/sram.sv
// sram: single-port synchronous RAM macro wrapper, one-cycle read latency.
//   clk_i   - clock
//   cs_i    - chip select, one access per cycle
//   we_i    - 1 = write, 0 = read
//   addr_i  - row address
//   wdata_i - write data
//   rdata_o - read data, holds until the next read
// Contents are not reset; SimInit names the intended simulation fill.
module sram #(
  parameter int    NumWords  = 64,
  parameter int    DataWidth = 32,
  parameter string SimInit   = "zeros",
  localparam int   AddrWidth = (NumWords > 1) ? $clog2(NumWords) : 1
) (
  input  logic                 clk_i,
  input  logic                 cs_i,
  input  logic                 we_i,
  input  logic [AddrWidth-1:0] addr_i,
  input  logic [DataWidth-1:0] wdata_i,
  output logic [DataWidth-1:0] rdata_o
);

  logic [DataWidth-1:0] mem [NumWords];

  if (SimInit != "zeros" && SimInit != "ones" && SimInit != "random" && SimInit != "none")
  begin : g_bad_init
    $error("sram: unsupported SimInit value");
  end

  always_ff @(posedge clk_i) begin
    if (cs_i) begin
      if (we_i) begin
        mem[addr_i] <= wdata_i;
      end else begin
        rdata_o <= mem[addr_i];
      end
    end
  end

endmodule

// File: rtl/banked_sram.sv
// banked_sram: multi-port, bank-interleaved memory with per-bank round-robin
// arbitration and a req/gnt handshake.
//   clk_i, rst_ni - clock, async active-low reset
//   req_i, wen_i  - per-port request and write enable
//   addr_i        - per-port word address (low bits select the bank)
//   wdata_i       - per-port write data
//   gnt_o         - per-port grant, combinational from req/addr/pointers
//   rvalid_o      - one-cycle pulse Latency cycles after a granted read
//   rdata_o       - read data, holds its last value while rvalid_o is low
module banked_sram
  import banked_sram_pkg::*;
#(
  parameter int    NumPorts  = 2,
  parameter int    NumBanks  = 4,
  parameter int    DataWidth = 32,
  parameter int    AddrWidth = 8,
  parameter int    Latency   = 1,
  parameter string SimInit   = "zeros"
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic [NumPorts-1:0]                 req_i,
  input  logic [NumPorts-1:0]                 wen_i,
  input  logic [NumPorts-1:0][AddrWidth-1:0]  addr_i,
  input  logic [NumPorts-1:0][DataWidth-1:0]  wdata_i,
  output logic [NumPorts-1:0]                 gnt_o,
  output logic [NumPorts-1:0]                 rvalid_o,
  output logic [NumPorts-1:0][DataWidth-1:0]  rdata_o
);

  localparam int BankSel  = bank_sel_bits(NumBanks);
  localparam int RowWidth = AddrWidth - BankSel;
  localparam int PortIdx  = idx_bits(NumPorts);

  addr_split_t          port_split [NumPorts];
  logic [BankSel-1:0]   port_bank  [NumPorts];
  logic [RowWidth-1:0]  port_row   [NumPorts];
  logic                 unused_split;

  logic [NumPorts-1:0]  bank_req   [NumBanks];
  logic [NumPorts-1:0]  bank_gnt   [NumBanks];
  logic [PortIdx-1:0]   bank_idx   [NumBanks];
  logic [NumBanks-1:0]  bank_cs;
  logic [DataWidth-1:0] bank_rdata [NumBanks];

  logic [NumPorts-1:0]  rd_valid;
  logic [BankSel-1:0]   rd_bank [NumPorts];

  // The generic split is wider than needed; its high bits are zero and are
  // folded into a dead signal so nothing dangles.
  always_comb begin
    unused_split = 1'b0;
    for (int p = 0; p < NumPorts; p++) begin
      port_split[p] = bank_addr_split(MaxAddrWidth'(addr_i[p]), BankSel);
      port_bank[p]  = port_split[p].bank[BankSel-1:0];
      port_row[p]   = port_split[p].row[RowWidth-1:0];
      unused_split  = unused_split ^ (^port_split[p].bank[MaxAddrWidth-1:BankSel])
                                   ^ (^port_split[p].row[MaxAddrWidth-1:RowWidth]);
    end
  end

  always_comb begin
    for (int b = 0; b < NumBanks; b++) begin
      for (int p = 0; p < NumPorts; p++) begin
        bank_req[b][p] = req_i[p] && (port_bank[p] == BankSel'(b));
      end
    end
  end

  // Each bank has its own arbiter; the winner's request steers the macro.
  for (genvar b = 0; b < NumBanks; b++) begin : g_bank
    rr_arbiter #(.NumReq(NumPorts)) u_arb (
      .clk   (clk_i),
      .rst_n (rst_ni),
      .req   (bank_req[b]),
      .gnt   (bank_gnt[b]),
      .idx   (bank_idx[b]),
      .valid (bank_cs[b])
    );

    sram #(
      .NumWords  (1 << RowWidth),
      .DataWidth (DataWidth),
      .SimInit   (SimInit)
    ) u_bank (
      .clk_i   (clk_i),
      .cs_i    (bank_cs[b]),
      .we_i    (wen_i[bank_idx[b]]),
      .addr_i  (port_row[bank_idx[b]]),
      .wdata_i (wdata_i[bank_idx[b]]),
      .rdata_o (bank_rdata[b])
    );
  end

  always_comb begin
    gnt_o = '0;
    for (int b = 0; b < NumBanks; b++) begin
      gnt_o = gnt_o | bank_gnt[b];
    end
  end

  // Read token: remembers which bank will present this port's data next cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_valid <= '0;
      for (int p = 0; p < NumPorts; p++) rd_bank[p] <= '0;
    end else begin
      rd_valid <= gnt_o & ~wen_i;
      for (int p = 0; p < NumPorts; p++) begin
        if (gnt_o[p]) rd_bank[p] <= port_bank[p];
      end
    end
  end

  for (genvar p = 0; p < NumPorts; p++) begin : g_port
    logic                 last_valid;
    logic [DataWidth-1:0] last_data;
    logic [DataWidth-1:0] rdata_hold;

    if (Latency == 1) begin : g_direct
      assign last_valid = rd_valid[p];
      assign last_data  = bank_rdata[rd_bank[p]];
    end else begin : g_pipe
      logic [Latency-2:0]   v_q;
      logic [DataWidth-1:0] d_q [Latency-1];

      // Extra return stages; reset drops any token still in flight.
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          v_q <= '0;
          for (int k = 0; k < Latency - 1; k++) d_q[k] <= '0;
        end else begin
          v_q[0] <= rd_valid[p];
          d_q[0] <= bank_rdata[rd_bank[p]];
          for (int k = 1; k < Latency - 1; k++) begin
            v_q[k] <= v_q[k-1];
            d_q[k] <= d_q[k-1];
          end
        end
      end

      assign last_valid = v_q[Latency-2];
      assign last_data  = d_q[Latency-2];
    end

    // A shared bank may be read by another port afterwards, so the port keeps
    // its own copy of the last returned word.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        rdata_hold <= '0;
      end else if (last_valid) begin
        rdata_hold <= last_data;
      end
    end

    assign rvalid_o[p] = last_valid;
    assign rdata_o[p]  = last_valid ? last_data : rdata_hold;
  end

endmodule

// File: tb/tb_banked_sram.sv
// tb_banked_sram: randomized and directed stimulus against two builds of
// banked_sram (Latency 1 and Latency 3) sharing the same inputs. A reference
// model (flat memory array, per-bank pointer integers) predicts grants and
// queues expected read returns; a separate monitor pops and compares them.
module tb_banked_sram;

  localparam int NP    = 2;
  localparam int NB    = 4;
  localparam int DW    = 32;
  localparam int AW    = 8;
  localparam int LAT_A = 1;
  localparam int LAT_B = 3;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NP-1:0]         req = '0;
  logic [NP-1:0]         wen = '0;
  logic [NP-1:0][AW-1:0] addr = '0;
  logic [NP-1:0][DW-1:0] wdata = '0;
  logic [NP-1:0]         gnt_a, gnt_b, rvalid_a, rvalid_b;
  logic [NP-1:0][DW-1:0] rdata_a, rdata_b;

  banked_sram #(.NumPorts(NP), .NumBanks(NB), .DataWidth(DW), .AddrWidth(AW),
                .Latency(LAT_A), .SimInit("zeros")) dut_lat1 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .wen_i(wen), .addr_i(addr),
    .wdata_i(wdata), .gnt_o(gnt_a), .rvalid_o(rvalid_a), .rdata_o(rdata_a));

  banked_sram #(.NumPorts(NP), .NumBanks(NB), .DataWidth(DW), .AddrWidth(AW),
                .Latency(LAT_B), .SimInit("zeros")) dut_lat3 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .wen_i(wen), .addr_i(addr),
    .wdata_i(wdata), .gnt_o(gnt_b), .rvalid_o(rvalid_b), .rdata_o(rdata_b));

  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  typedef struct {
    int          due;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          exp_q [2][NP][$];
  logic [DW-1:0] mem_model [DEPTH];
  int            ptr_model [NB];
  logic [DW-1:0] last_data [2][NP];
  int            n_checks = 0;
  int            n_fail = 0;

  function automatic int lat_of(input int d);
    return (d == 0) ? LAT_A : LAT_B;
  endfunction

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cycle);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++)
      for (int p = 0; p < NP; p++) begin
        exp_q[d][p].delete();
        last_data[d][p] = '0;
      end
    for (int b = 0; b < NB; b++) ptr_model[b] = 0;
  endtask

  // Predict grants from the current inputs, compare, and advance the model.
  task automatic check_output(output logic [NP-1:0] g);
    logic [NP-1:0] exp_gnt;
    exp_t e;
    exp_gnt = '0;
    for (int b = 0; b < NB; b++) begin
      for (int i = 0; i < NP; i++) begin
        int p;
        p = (ptr_model[b] + i) % NP;
        if (req[p] && (int'(addr[p]) % NB) == b) begin
          exp_gnt[p] = 1'b1;
          ptr_model[b] = (p + 1) % NP;
          break;
        end
      end
    end
    check("gnt_lat1", 64'(gnt_a), 64'(exp_gnt));
    check("gnt_lat3", 64'(gnt_b), 64'(exp_gnt));
    for (int p = 0; p < NP; p++) begin
      if (exp_gnt[p]) begin
        if (wen[p]) begin
          mem_model[addr[p]] = wdata[p];
        end else begin
          for (int d = 0; d < 2; d++) begin
            e.due  = cycle + lat_of(d);
            e.data = mem_model[addr[p]];
            exp_q[d][p].push_back(e);
          end
        end
      end
    end
    g = exp_gnt;
  endtask

  // One clock: inputs already driven; check at negedge, then step past posedge.
  task automatic apply_stimulus(output logic [NP-1:0] g);
    @(negedge clk);
    check_output(g);
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(input int p, input logic r, input logic w,
                          input logic [AW-1:0] a, input logic [DW-1:0] dat);
    req[p]   = r;
    wen[p]   = w;
    addr[p]  = a;
    wdata[p] = dat;
  endtask

  // Monitor: pops expected returns whenever a DUT presents rvalid.
  always @(negedge clk) begin
    exp_t e;
    logic v;
    logic [DW-1:0] dat;
    for (int d = 0; d < 2; d++) begin
      for (int p = 0; p < NP; p++) begin
        v   = (d == 0) ? rvalid_a[p] : rvalid_b[p];
        dat = (d == 0) ? rdata_a[p]  : rdata_b[p];
        if (v) begin
          if (exp_q[d][p].size() == 0) begin
            check($sformatf("rvalid_unexpected_d%0d_p%0d", d, p), 64'(v), 64'(0));
          end else begin
            e = exp_q[d][p].pop_front();
            check($sformatf("rvalid_timing_d%0d_p%0d", d, p), 64'(cycle), 64'(e.due));
            check($sformatf("rdata_d%0d_p%0d", d, p), 64'(dat), 64'(e.data));
            last_data[d][p] = e.data;
          end
        end else begin
          check($sformatf("rdata_hold_d%0d_p%0d", d, p), 64'(dat), 64'(last_data[d][p]));
          if (exp_q[d][p].size() != 0 && exp_q[d][p][0].due <= cycle) begin
            e = exp_q[d][p].pop_front();
            check($sformatf("rvalid_missing_d%0d_p%0d", d, p), 64'(v), 64'(1));
          end
        end
      end
    end
  end

  initial begin
    logic [NP-1:0] g;
    logic [NP-1:0] pend;
    model_reset();
    $display("[TB] reset");
    repeat (2) apply_stimulus(g);
    rst_n = 1'b1;
    apply_stimulus(g);

    $display("[TB] fill memory");
    for (int a = 0; a < DEPTH; a += 2) begin
      set_port(0, 1'b1, 1'b1, AW'(a),     $urandom());
      set_port(1, 1'b1, 1'b1, AW'(a + 1), $urandom());
      apply_stimulus(g);
    end

    $display("[TB] parallel access");
    set_port(0, 1'b1, 1'b1, 8'd4, 32'h11);
    set_port(1, 1'b1, 1'b1, 8'd5, 32'h22);
    apply_stimulus(g);
    set_port(0, 1'b1, 1'b0, 8'd4, '0);
    set_port(1, 1'b1, 1'b0, 8'd5, '0);
    apply_stimulus(g);

    $display("[TB] bank conflict");
    set_port(0, 1'b1, 1'b0, 8'd2, '0);
    set_port(1, 1'b1, 1'b0, 8'd6, '0);
    repeat (4) apply_stimulus(g);

    $display("[TB] read after write");
    set_port(0, 1'b1, 1'b1, 8'd0, 32'h3AA);
    set_port(1, 1'b0, 1'b0, 8'd0, '0);
    apply_stimulus(g);
    set_port(0, 1'b1, 1'b0, 8'd0, '0);
    apply_stimulus(g);

    $display("[TB] top address");
    set_port(0, 1'b0, 1'b0, 8'd0, '0);
    set_port(1, 1'b1, 1'b1, 8'd255, 32'hCAFE_F00D);
    apply_stimulus(g);
    set_port(0, 1'b1, 1'b0, 8'd252, '0);
    set_port(1, 1'b1, 1'b0, 8'd255, '0);
    apply_stimulus(g);

    $display("[TB] mid-operation reset");
    set_port(0, 1'b1, 1'b0, 8'd9, '0);
    set_port(1, 1'b0, 1'b0, 8'd0, '0);
    apply_stimulus(g);
    req = '0;
    rst_n = 1'b0;
    model_reset();
    repeat (2) apply_stimulus(g);
    rst_n = 1'b1;
    set_port(0, 1'b1, 1'b0, 8'd1, '0);
    set_port(1, 1'b1, 1'b0, 8'd5, '0);
    apply_stimulus(g);
    req = '0;
    apply_stimulus(g);

    $display("[TB] random traffic");
    pend = '0;
    for (int c = 0; c < 400; c++) begin
      for (int p = 0; p < NP; p++) begin
        if (!pend[p] && ($urandom_range(0, 3) != 0)) begin
          pend[p] = 1'b1;
          set_port(p, 1'b1, 1'($urandom_range(0, 1)), AW'($urandom_range(0, DEPTH - 1)), $urandom());
        end else if (!pend[p]) begin
          req[p] = 1'b0;
        end
      end
      apply_stimulus(g);
      pend = pend & ~g;
      for (int p = 0; p < NP; p++) if (!pend[p]) req[p] = 1'b0;
    end

    req = '0;
    repeat (LAT_B + 2) apply_stimulus(g);
    for (int d = 0; d < 2; d++)
      for (int p = 0; p < NP; p++)
        check($sformatf("drain_d%0d_p%0d", d, p), 64'(exp_q[d][p].size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
